// File: rtl/rename_regfile.sv
// Architectural register file with rename-tag tracking, commit bypass on reads,
// and branch checkpoints of the busy/tag map restorable in one cycle.
module rename_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NCKPT = 4,
    parameter int unsigned CW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD-1:0]      rd_busy,
    output logic [NRD*XLEN-1:0] rd_val,
    input  logic                ren_en,
    input  logic [AW-1:0]       ren_rd,
    input  logic [TAG_W-1:0]    ren_tag,
    input  logic                cm_en,
    input  logic [AW-1:0]       cm_rd,
    input  logic [TAG_W-1:0]    cm_tag,
    input  logic [XLEN-1:0]     cm_data,
    input  logic                ck_save,
    input  logic [CW-1:0]       ck_save_id,
    input  logic                ck_restore,
    input  logic [CW-1:0]       ck_restore_id
);

    logic [XLEN-1:0]  v    [NREG];
    logic [NREG-1:0]  b;
    logic [TAG_W-1:0] q    [NREG];
    logic [NREG-1:0]  sb   [NCKPT];
    logic [TAG_W-1:0] sq   [NCKPT][NREG];

    logic [NREG-1:0]  b_nx;
    logic [TAG_W-1:0] q_nx [NREG];

    logic cm_wr;
    logic ren_wr;
    logic save_wr;

    assign cm_wr   = cm_en && (cm_rd != '0);
    assign ren_wr  = ren_en && (ren_rd != '0) && !ck_restore;
    assign save_wr = ck_save && !ck_restore;

    // Next live map: restore base, then commit clear, then rename on top.
    always_comb begin
        b_nx = b;
        q_nx = q;
        if (ck_restore) begin
            b_nx = sb[ck_restore_id];
            q_nx = sq[ck_restore_id];
        end
        if (cm_wr && (q_nx[cm_rd] == cm_tag)) begin
            b_nx[cm_rd] = 1'b0;
        end
        if (ren_wr) begin
            b_nx[ren_rd] = 1'b1;
            q_nx[ren_rd] = ren_tag;
        end
    end

    // Tags are never reset: they are only observed while the busy bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            b <= '0;
            for (int unsigned s = 0; s < NCKPT; s++) begin
                sb[CW'(s)] <= '0;
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                v[AW'(r)] <= '0;
            end
        end else if (flush) begin
            b <= '0;
            for (int unsigned s = 0; s < NCKPT; s++) begin
                sb[CW'(s)] <= '0;
            end
            if (cm_wr) begin
                v[cm_rd] <= cm_data;
            end
        end else if (rdy) begin
            if (cm_wr) begin
                v[cm_rd] <= cm_data;
            end
            b <= b_nx;
            q <= q_nx;
            // Retire the committing tag from every snapshot so a restore cannot revive it.
            for (int unsigned s = 0; s < NCKPT; s++) begin
                if (cm_wr && sb[CW'(s)][cm_rd] && (sq[CW'(s)][cm_rd] == cm_tag)) begin
                    sb[CW'(s)][cm_rd] <= 1'b0;
                end
            end
            if (save_wr) begin
                sb[ck_save_id] <= b_nx;
                sq[ck_save_id] <= q_nx;
            end
        end
    end

    // Combinational read ports against the pre-clock live map.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            busy;
        logic [XLEN-1:0] val;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            busy = 1'b0;
            val  = '0;
            if (rd_en[k] && (addr != '0)) begin
                if (!b[addr]) begin
                    val = v[addr];
                end else if (cm_en && (cm_tag == q[addr])) begin
                    val = cm_data;
                end else begin
                    busy = 1'b1;
                    val  = XLEN'(q[addr]);
                end
            end
        end

        assign rd_busy[k]              = busy;
        assign rd_val[k*XLEN +: XLEN]  = val;
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed plan plus randomized traffic
// checked every cycle against a behavioural model of the register/rename state.
module tb_rename_regfile;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NCKPT = 4;
    localparam int unsigned CW    = 2;

    logic                clk;
    logic                rst;
    logic                rdy;
    logic                flush;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_busy;
    logic [NRD*XLEN-1:0] rd_val;
    logic                ren_en;
    logic [AW-1:0]       ren_rd;
    logic [TAG_W-1:0]    ren_tag;
    logic                cm_en;
    logic [AW-1:0]       cm_rd;
    logic [TAG_W-1:0]    cm_tag;
    logic [XLEN-1:0]     cm_data;
    logic                ck_save;
    logic [CW-1:0]       ck_save_id;
    logic                ck_restore;
    logic [CW-1:0]       ck_restore_id;

    int n_checks = 0;
    int n_errors = 0;

    rename_regfile #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .TAG_W(TAG_W),
        .NRD(NRD), .NCKPT(NCKPT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_val(rd_val),
        .ren_en(ren_en), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .ck_save(ck_save), .ck_save_id(ck_save_id),
        .ck_restore(ck_restore), .ck_restore_id(ck_restore_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain arrays for values, live map and snapshots.
    logic [31:0] mv  [NREG];
    bit          mb  [NREG];
    bit   [3:0]  mq  [NREG];
    bit          msb [NCKPT][NREG];
    bit   [3:0]  msq [NCKPT][NREG];

    always @(posedge clk) begin
        bit       nb [NREG];
        bit [3:0] nq [NREG];
        int       c;
        c = int'(cm_rd);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mv[r] = 0;
                mb[r] = 0;
                for (int s = 0; s < NCKPT; s++) msb[s][r] = 0;
            end
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                mb[r] = 0;
                for (int s = 0; s < NCKPT; s++) msb[s][r] = 0;
            end
            if (cm_en && c != 0) mv[c] = cm_data;
        end else if (rdy) begin
            for (int r = 0; r < NREG; r++) begin
                nb[r] = ck_restore ? msb[ck_restore_id][r] : mb[r];
                nq[r] = ck_restore ? msq[ck_restore_id][r] : mq[r];
            end
            if (cm_en && c != 0) begin
                mv[c] = cm_data;
                if (nq[c] == cm_tag) nb[c] = 0;
                for (int s = 0; s < NCKPT; s++)
                    if (msb[s][c] && msq[s][c] == cm_tag) msb[s][c] = 0;
            end
            if (ren_en && ren_rd != 0 && !ck_restore) begin
                nb[ren_rd] = 1;
                nq[ren_rd] = ren_tag;
            end
            if (ck_save && !ck_restore) begin
                for (int r = 0; r < NREG; r++) begin
                    msb[ck_save_id][r] = nb[r];
                    msq[ck_save_id][r] = nq[r];
                end
            end
            for (int r = 0; r < NREG; r++) begin
                mb[r] = nb[r];
                mq[r] = nq[r];
            end
        end
    end

    function automatic void model_read(input bit en, input int a,
                                       output bit eb, output logic [31:0] ev);
        eb = 0;
        ev = 0;
        if (!en || a == 0) return;
        if (!mb[a]) ev = mv[a];
        else if (cm_en && cm_tag == mq[a]) ev = cm_data;
        else begin
            eb = 1;
            ev = 32'(mq[a]);
        end
    endfunction

    // Per-cycle compare of every read port against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NRD; k++) begin
                bit          eb;
                logic [31:0] ev;
                logic [31:0] gv;
                model_read(rd_en[k], int'(rd_addr[k*AW +: AW]), eb, ev);
                gv = rd_val[k*XLEN +: XLEN];
                n_checks++;
                if (rd_busy[k] !== eb || gv !== ev) begin
                    n_errors++;
                    $display("FAIL model_port%0d t=%0t addr=%0d: got busy=%b val=%h expected busy=%b val=%h",
                             k, $time, rd_addr[k*AW +: AW], rd_busy[k], gv, eb, ev);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst        = 0;
        flush      = 0;
        rdy        = 1;
        ren_en     = 0;
        cm_en      = 0;
        ck_save    = 0;
        ck_restore = 0;
    endtask

    task automatic rd(input int a1, input int a0);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic ren(input int r, input int t);
        ren_en  = 1;
        ren_rd  = AW'(r);
        ren_tag = TAG_W'(t);
    endtask

    task automatic cm(input int r, input int t, input logic [31:0] d);
        cm_en   = 1;
        cm_rd   = AW'(r);
        cm_tag  = TAG_W'(t);
        cm_data = d;
    endtask

    initial begin
        rst = 1; rdy = 1; flush = 0; rd_en = 2'b11; rd_addr = '0;
        ren_en = 0; ren_rd = '0; ren_tag = '0;
        cm_en = 0; cm_rd = '0; cm_tag = '0; cm_data = '0;
        ck_save = 0; ck_save_id = '0; ck_restore = 0; ck_restore_id = '0;
        repeat (2) @(posedge clk);
        tick();

        // Reset state, commit to a non-busy register.
        rd(5, 5); cm(5, 3, 32'hDEADBEEF);
        @(negedge clk);
        chk("rst_busy", 64'(rd_busy), 64'h0);
        chk("rst_val", rd_val, 64'h0);
        tick();
        rd(5, 5); ren(7, 9);
        @(negedge clk);
        chk("cm_x5", rd_val, {32'hDEADBEEF, 32'hDEADBEEF});
        chk("model_v5", 64'(mv[5]), 64'hDEADBEEF);
        tick();
        rd(7, 7);
        @(negedge clk);
        chk("ren_busy", 64'(rd_busy), 64'h3);
        chk("ren_tag", rd_val, {32'h9, 32'h9});
        tick();

        // Same-cycle commit bypass.
        rd(5, 7); cm(7, 9, 32'h55);
        @(negedge clk);
        chk("byp_busy", 64'(rd_busy), 64'h0);
        chk("byp_val", rd_val, {32'hDEADBEEF, 32'h55});
        tick();
        rd(7, 7); ren(7, 2); cm(7, 1, 32'h66);
        @(negedge clk);
        chk("cleared_val", rd_val, {32'h55, 32'h55});
        tick();

        // Rename wins over a non-matching commit; value still written.
        rd(7, 7); flush = 1;
        @(negedge clk);
        chk("ren_over_cm", {62'(rd_busy), 2'b00} | 64'(rd_val[31:0]), {62'h3, 2'b00} | 64'h2);
        tick();
        rd(7, 7); ren(3, 4);
        @(negedge clk);
        chk("cm_v7", rd_val, {32'h66, 32'h66});
        chk("model_b7", 64'(mb[7]), 64'h0);
        tick();

        // Checkpoint save and restore.
        rd(3, 3); ck_save = 1; ck_save_id = 2'd1;
        @(negedge clk);
        chk("x3_tag4", rd_val, {32'h4, 32'h4});
        tick();
        ren(3, 6);
        tick();
        rd(3, 3); ren(8, 7);
        @(negedge clk);
        chk("x3_tag6", rd_val, {32'h6, 32'h6});
        tick();
        rd(8, 3); ck_restore = 1; ck_restore_id = 2'd1;
        @(negedge clk);
        chk("pre_rst_busy", 64'(rd_busy), 64'h3);
        chk("pre_rst_val", rd_val, {32'h7, 32'h6});
        tick();
        rd(8, 3); ck_save = 1; ck_save_id = 2'd0;
        @(negedge clk);
        chk("restored_busy", 64'(rd_busy), 64'h1);
        chk("restored_val", rd_val, {32'h0, 32'h4});
        tick();

        // Commit clears the snapshot too.
        rd(3, 3); cm(3, 4, 32'h1234);
        @(negedge clk);
        chk("byp_x3", {62'(rd_busy), 2'b00} | 64'(rd_val[31:0]), 64'h1234);
        tick();
        rd(3, 3); ck_restore = 1; ck_restore_id = 2'd0;
        tick();
        rd(3, 3); ren(1, 1);
        @(negedge clk);
        chk("no_resurrect_busy", 64'(rd_busy), 64'h0);
        chk("no_resurrect_val", rd_val, {32'h1234, 32'h1234});
        tick();

        // Flush with same-cycle commit.
        ren(2, 2);
        tick();
        rd(2, 1); ren(4, 5);
        @(negedge clk);
        chk("multi_busy", 64'(rd_busy), 64'h3);
        chk("multi_tag", rd_val, {32'h2, 32'h1});
        tick();
        flush = 1; cm(1, 0, 32'hA);
        tick();
        rd(2, 1); ck_restore = 1; ck_restore_id = 2'd1;
        @(negedge clk);
        chk("flush_busy", 64'(rd_busy), 64'h0);
        chk("flush_val", rd_val, {32'h0, 32'hA});
        tick();
        rd(4, 3); ren(0, 3);
        @(negedge clk);
        chk("post_flush_rst_busy", 64'(rd_busy), 64'h0);
        chk("post_flush_rst_val", rd_val, {32'h0, 32'h1234});
        tick();
        rd(0, 0);
        @(negedge clk);
        chk("x0_busy", 64'(rd_busy), 64'h0);
        chk("x0_val", rd_val, 64'h0);
        tick();

        // Randomized traffic on a small register window for frequent collisions.
        for (int i = 0; i < 3000; i++) begin
            int c;
            rst           = ($urandom_range(0, 499) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            rdy           = flush ? 1'b1 : ($urandom_range(0, 9) != 0);
            rd_en         = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            rd_addr       = {AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9))};
            ren_en        = 1'($urandom);
            ren_rd        = AW'($urandom_range(0, 9));
            ren_tag       = TAG_W'($urandom);
            cm_en         = 1'($urandom);
            c             = $urandom_range(0, 9);
            cm_rd         = AW'(c);
            cm_tag        = ($urandom_range(0, 9) < 7) ? mq[c] : TAG_W'($urandom);
            cm_data       = $urandom;
            ck_save       = ($urandom_range(0, 4) == 0);
            ck_save_id    = CW'($urandom);
            ck_restore    = ($urandom_range(0, 9) == 0);
            ck_restore_id = CW'($urandom);
            @(posedge clk);
            #1;
        end

        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
